// File: rtl/router_pkg.sv
// Shared router/merge definitions: channel count, channel-index type and the
// packet-lock state encoding.
package router_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_st_t;
endpackage

// File: rtl/merge_8to1_rr_arb8.sv
// rr_arb8: 8-way round-robin priority search. It starts at ptr, moves upward
// and wraps from 7 to 0. Only requests whose mask bit is set are eligible.
module rr_arb8
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] gnt_oh,
  output ch_idx_t           gnt_idx,
  output logic              any_gnt
);
  logic [NUM_CH-1:0] elig;
  assign elig = req & mask;

  // Walk the offsets from farthest to nearest, so the last hit is the nearest one.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (elig[ptr + ch_idx_t'(k)]) begin
        gnt_idx = ptr + ch_idx_t'(k);
        any_gnt = 1'b1;
      end
    end
    gnt_oh[gnt_idx] = any_gnt;
  end
endmodule

// File: rtl/merge_8to1.sv
// merge_8to1: 8-channel round-robin merge into one output register stage.
// When MERGE_8TO1_PKT_LOCK_EN is defined, the arbiter holds a channel until
// the last beat of its packet.
module merge_8to1
  import router_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0][DW-1:0]  in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH-1:0]          in_last,
  output logic [NUM_CH-1:0]          in_ready,
  output logic [DW-1:0]              out_data,
  output ch_idx_t                    out_src,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);
  logic              load, accept, advance, any_gnt;
  logic [NUM_CH-1:0] mask, gnt_oh;
  ch_idx_t           gnt_idx, ptr;

  assign load = !out_valid || out_ready;

  rr_arb8 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mask    (mask),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Gating with rst_n keeps in_ready at 0 while reset is held, even though
  // load is already 1 at that time.
  assign accept   = load && any_gnt && rst_n;
  assign in_ready = accept ? gnt_oh : '0;

`ifdef MERGE_8TO1_PKT_LOCK_EN
  lock_st_t st_q, st_d;
  ch_idx_t  lk_ch_q, lk_ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= LK_IDLE;
      lk_ch_q <= '0;
    end else begin
      st_q    <= st_d;
      lk_ch_q <= lk_ch_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    lk_ch_d = lk_ch_q;
    mask    = '1;
    case (st_q)
      LK_IDLE: begin
        if (accept && !in_last[gnt_idx]) begin
          st_d    = LK_LOCKED;
          lk_ch_d = gnt_idx;
        end
      end
      LK_LOCKED: begin
        mask          = '0;
        mask[lk_ch_q] = 1'b1;
        if (accept && in_last[gnt_idx]) st_d = LK_IDLE;
      end
      default: st_d = LK_IDLE;
    endcase
  end

  // Move the pointer only when a packet ends, so a locked packet is not cut.
  assign advance = accept && in_last[gnt_idx];
`else
  assign mask    = '1;
  assign advance = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= any_gnt;
        if (any_gnt) begin
          out_data <= in_data[gnt_idx];
          out_src  <= gnt_idx;
          out_last <= in_last[gnt_idx];
        end
      end
      if (advance) ptr <= gnt_idx + ch_idx_t'(1);
    end
  end
endmodule
